// File: rtl/sisc_fetch_if.sv
// sisc_fetch_if: instruction-memory read channel between the fetch stage and
// instruction memory.
//   imem_req  : fetch -> memory, read request
//   imem_addr : fetch -> memory, word address
//   imem_ack  : memory -> fetch, read data valid (may coincide with imem_req)
//   imem_data : memory -> fetch, read data
// modport master is the fetch side, modport slave is the memory side.
interface sisc_fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction-fetch stage feeding the SISC datapath.
// Holds the PC, reads one word at a time from instruction memory, keeps one
// prefetched word in a buffer and moves it into ir when the controller asks.
// A branch redirect flushes the buffer and restarts fetch at the target.
// Ports:
//   clk      : clock, rising edge
//   rst_f    : asynchronous active-low reset
//   ir_load  : controller request to move the buffered word into ir
//   br_taken : one-cycle branch redirect
//   br_addr  : branch target word address
//   imem     : instruction memory channel (master side)
//   ir       : instruction register
//   ir_pc    : word address of the instruction in ir
//   ir_valid : ir holds a fetched instruction
//   stall    : buffer empty, an ir_load this cycle is ignored
module sisc_fetch #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               ir_load,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_addr,
  sisc_fetch_if.master       imem,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  output logic               stall
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] buf_r;
  logic [PC_W-1:0]    buf_pc_r;
  logic               buf_valid_r;
  logic [INSTR_W-1:0] ir_r;
  logic [PC_W-1:0]    ir_pc_r;
  logic               ir_valid_r;
  logic               redirect_s;
  logic               capture_s;
  logic               load_s;
  logic               req_s;

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-cycle event decode; a redirect outranks both a
  // same-cycle ack and a same-cycle ir_load.
  always_comb begin
    state_nxt_s = state_r;
    redirect_s  = 1'b0;
    capture_s   = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (br_taken) begin
          redirect_s  = 1'b1;
          state_nxt_s = ST_FETCH;
        end else if (imem.imem_ack) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_FULL: begin
        if (br_taken) begin
          redirect_s  = 1'b1;
          state_nxt_s = ST_FETCH;
        end else if (ir_load) begin
          load_s      = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        // Unreachable encoding: restart cleanly through IDLE.
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: a request is outstanding only while fetching.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      ST_FETCH: req_s = 1'b1;
      ST_IDLE:  req_s = 1'b0;
      ST_FULL:  req_s = 1'b0;
      default:  req_s = 1'b0;
    endcase
  end

  // PC, prefetch buffer and instruction register updates.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_r        <= RESET_PC;
      buf_r       <= '0;
      buf_pc_r    <= '0;
      buf_valid_r <= 1'b0;
      ir_r        <= '0;
      ir_pc_r     <= '0;
      ir_valid_r  <= 1'b0;
    end else if (redirect_s) begin
      pc_r        <= br_addr;
      buf_valid_r <= 1'b0;
    end else if (capture_s) begin
      buf_r       <= imem.imem_data;
      buf_pc_r    <= pc_r;
      buf_valid_r <= 1'b1;
      // Wraps modulo 2^PC_W.
      pc_r        <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    end else if (load_s) begin
      ir_r        <= buf_r;
      ir_pc_r     <= buf_pc_r;
      ir_valid_r  <= 1'b1;
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_r;
  assign ir             = ir_r;
  assign ir_pc          = ir_pc_r;
  assign ir_valid       = ir_valid_r;
  assign stall          = ~buf_valid_r;

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: randomized and directed bench for sisc_fetch with an
// abstract reference model (one-deep buffer, pc, ir) and a second instance
// using RESET_PC=0xFFFF to exercise pc wrap.
module tb_sisc_fetch;

  logic        clk;
  logic        rst_f;
  logic        ir_load;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        ack_r;
  int          mem_mode;
  int          wcnt;
  int          checks;
  int          errors;

  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        stall;

  logic        ir_load_w;
  logic        br_taken_w;
  logic [15:0] br_addr_w;
  logic [31:0] ir_w;
  logic [15:0] ir_pc_w;
  logic        ir_valid_w;
  logic        stall_w;

  sisc_fetch_if #(.PC_W(16), .INSTR_W(32)) bus ();
  sisc_fetch_if #(.PC_W(16), .INSTR_W(32)) bus_w ();

  // Memory contents: word at address a is 0xA500_0000 | a; garbage when no ack.
  assign bus.imem_ack    = ack_r;
  assign bus.imem_data   = ack_r ? (32'hA500_0000 | {16'h0000, bus.imem_addr}) : 32'hDEAD_BEEF;
  assign bus_w.imem_ack  = 1'b1;
  assign bus_w.imem_data = 32'hA500_0000 | {16'h0000, bus_w.imem_addr};

  sisc_fetch #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) u_dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .ir_load  (ir_load),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .imem     (bus),
    .ir       (ir),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .stall    (stall)
  );

  sisc_fetch #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'hFFFF)) u_dut_w (
    .clk      (clk),
    .rst_f    (rst_f),
    .ir_load  (ir_load_w),
    .br_taken (br_taken_w),
    .br_addr  (br_addr_w),
    .imem     (bus_w),
    .ir       (ir_w),
    .ir_pc    (ir_pc_w),
    .ir_valid (ir_valid_w),
    .stall    (stall_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: after reset the stage spends one cycle starting up,
  // then either waits for a word (buffer empty) or holds one (buffer full).
  logic        m_started;
  logic [15:0] m_pc;
  logic        m_buf_valid;
  logic [15:0] m_buf_pc;
  logic [31:0] m_buf_d;
  logic [31:0] m_ir;
  logic [15:0] m_ir_pc;
  logic        m_ir_valid;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'hA500_0000 | {16'h0000, a};
  endfunction

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      m_started   <= 1'b0;
      m_pc        <= 16'h0000;
      m_buf_valid <= 1'b0;
      m_buf_pc    <= 16'h0000;
      m_buf_d     <= 32'h0000_0000;
      m_ir        <= 32'h0000_0000;
      m_ir_pc     <= 16'h0000;
      m_ir_valid  <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (br_taken) begin
      m_pc        <= br_addr;
      m_buf_valid <= 1'b0;
    end else if (!m_buf_valid) begin
      if (ack_r) begin
        m_buf_valid <= 1'b1;
        m_buf_pc    <= m_pc;
        m_buf_d     <= mem_word(m_pc);
        m_pc        <= m_pc + 16'd1;
      end
    end else if (ir_load) begin
      m_ir        <= m_buf_d;
      m_ir_pc     <= m_buf_pc;
      m_ir_valid  <= 1'b1;
      m_buf_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("imem_req",  {31'd0, bus.imem_req}, {31'd0, m_started & ~m_buf_valid});
    chk("imem_addr", {16'd0, bus.imem_addr}, {16'd0, m_pc});
    chk("stall",     {31'd0, stall}, {31'd0, ~m_buf_valid});
    chk("ir",        ir, m_ir);
    chk("ir_pc",     {16'd0, ir_pc}, {16'd0, m_ir_pc});
    chk("ir_valid",  {31'd0, ir_valid}, {31'd0, m_ir_valid});
  endtask

  // Memory responder: 0 = zero-wait, 1 = three wait cycles, else random ack.
  task automatic drive_mem();
    if (mem_mode == 0) begin
      ack_r = 1'b1;
    end else if (mem_mode == 1) begin
      if (bus.imem_req) begin
        ack_r = (wcnt >= 3);
        wcnt  = ack_r ? 0 : wcnt + 1;
      end else begin
        ack_r = 1'b0;
        wcnt  = 0;
      end
    end else begin
      ack_r = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    drive_mem();
  endtask

  initial begin
    logic [31:0] prev_ir;
    int          last_n;
    checks     = 0;
    errors     = 0;
    rst_f      = 1'b0;
    ir_load    = 1'b0;
    br_taken   = 1'b0;
    br_addr    = 16'h0000;
    ack_r      = 1'b0;
    mem_mode   = 0;
    wcnt       = 0;
    ir_load_w  = 1'b1;
    br_taken_w = 1'b0;
    br_addr_w  = 16'h0000;

    repeat (3) tick();
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr",  {16'd0, bus.imem_addr}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_ir",    ir, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_w_addr", {16'd0, bus_w.imem_addr}, 32'h0000_FFFF);

    // Zero-wait memory, ir_load held, then a redirect colliding with ack and ir_load.
    ir_load = 1'b1;
    rst_f   = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 3) begin
        chk("p1_ir0",    ir, 32'hA500_0000);
        chk("p1_irpc0",  {16'd0, ir_pc}, 32'd0);
        chk("p1_valid",  {31'd0, ir_valid}, 32'd1);
        chk("wrap_irpc", {16'd0, ir_pc_w}, 32'h0000_FFFF);
        chk("wrap_addr", {16'd0, bus_w.imem_addr}, 32'd0);
      end
      if (n == 5) begin
        chk("p1_ir1",     ir, 32'hA500_0001);
        chk("wrap_irpc2", {16'd0, ir_pc_w}, 32'd0);
        chk("wrap_ir2",   ir_w, 32'hA500_0000);
      end
      if (n == 7) begin
        chk("p1_ir2",   ir, 32'hA500_0002);
        chk("p1_irpc2", {16'd0, ir_pc}, 32'd2);
        chk("p1_addr3", {16'd0, bus.imem_addr}, 32'd3);
        br_taken = 1'b1;
        br_addr  = 16'h0040;
      end
      if (n == 8) begin
        br_taken = 1'b0;
        chk("br_addr",  {16'd0, bus.imem_addr}, 32'h0000_0040);
        chk("br_ir",    ir, 32'hA500_0002);
        chk("br_stall", {31'd0, stall}, 32'd1);
      end
      if (n == 10) begin
        chk("br_irpc", {16'd0, ir_pc}, 32'h0000_0040);
        chk("br_ir2",  ir, 32'hA500_0040);
      end
    end

    // Three-wait memory; ir_load pulsed while stalled must be ignored.
    rst_f   = 1'b0;
    ir_load = 1'b0;
    mem_mode = 1;
    repeat (2) tick();
    rst_f = 1'b1;
    prev_ir = 32'h0;
    last_n  = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) ir_load = 1'b1;
      if (n == 2) ir_load = 1'b0;
      if (n == 10) begin
        chk("pulse_valid", {31'd0, ir_valid}, 32'd0);
        chk("pulse_ir",    ir, 32'd0);
        chk("pulse_stall", {31'd0, stall}, 32'd0);
        ir_load = 1'b1;
      end
      if (n == 11) begin
        chk("pulse_load", ir, 32'hA500_0000);
        chk("pulse_lv",   {31'd0, ir_valid}, 32'd1);
        prev_ir = ir;
        last_n  = n;
      end
      if (n > 11 && ir !== prev_ir) begin
        chk("wait_interval", n - last_n, 32'd5);
        prev_ir = ir;
        last_n  = n;
      end
    end

    // Random ack, ir_load and redirects.
    mem_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      tick();
      ir_load  = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 15) == 0);
      br_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
    end

    // Asynchronous reset in the middle of a FETCH cycle.
    mem_mode = 1;
    ir_load  = 1'b0;
    br_taken = 1'b1;
    br_addr  = 16'h1234;
    tick();
    br_taken = 1'b0;
    #2;
    rst_f = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("arst_ir",    ir, 32'd0);
    chk("arst_valid", {31'd0, ir_valid}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd1);
    repeat (2) tick();
    rst_f = 1'b1;
    tick();
    chk("arst_restart_addr", {16'd0, bus.imem_addr}, 32'd0);
    chk("arst_restart_req",  {31'd0, bus.imem_req}, 32'd1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
